// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock,
// start/busy/done handshake with registered sum, carry_out and signed overflow.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad
    $error("serial_addsub: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, psum, psum_nxt;
  logic [CW-1:0]    cnt;
  logic             c, a_msb, b_msb;
  logic [DIGIT:0]   slice;
  // One DIGIT-bit full-adder slice; results enter the partial sum from the MSB side.
  always_comb begin
    slice    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(c);
    psum_nxt = (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT)) | (psum >> DIGIT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      psum      <= '0;
      cnt       <= '0;
      c         <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            a_msb <= a[WIDTH-1];
            b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            c     <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          c    <= slice[DIGIT];
          psum <= psum_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            sum       <= psum_nxt;
            carry_out <= slice[DIGIT];
            overflow  <= (a_msb == b_msb) && (psum_nxt[WIDTH-1] != a_msb);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: table-driven and sequence checks of serial_addsub at
// WIDTH=8/DIGIT=1 and WIDTH=16/DIGIT=4, plus a random run against an a+/-b model.
module tb_serial_addsub;
  logic        clk, rst_n;
  logic        start8, sub8, busy8, done8, co8, ov8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, sub16, busy16, done16, co16, ov16;
  logic [15:0] a16, b16, sum16;
  int          tests, fails;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8));

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .carry_out(co16), .overflow(ov16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    logic [15:0] a, b;
    logic        sub;
    bit          dis;
    logic [15:0] sum;
    logic        co, ov;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Runs one operation; optionally disturbs inputs and pulses start mid-RUN.
  task automatic op(input bit w, input logic [15:0] av, input logic [15:0] bv, input logic sv,
                    input bit dis, output logic [15:0] rs, output logic rc, output logic rv,
                    output int bc, output int extra);
    int cyc;
    @(negedge clk);
    if (w) begin a16 = av; b16 = bv; sub16 = sv; start16 = 1'b1; end
    else begin a8 = av[7:0]; b8 = bv[7:0]; sub8 = sv; start8 = 1'b1; end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0; bc = 0; cyc = 0;
    while (!(w ? done16 : done8) && cyc < 40) begin
      if (w ? busy16 : busy8) bc++;
      if (dis && cyc == 2) begin
        a8 = ~a8; b8 = b8 + 8'h11; sub8 = ~sub8;
        a16 = ~a16; b16 = b16 + 16'h1111; sub16 = ~sub16;
        start8 = 1'b1; start16 = 1'b1;
      end else begin
        start8 = 1'b0; start16 = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    start8 = 1'b0; start16 = 1'b0;
    chk("done_timeout", 32'(cyc >= 40), 32'd0);
    chk("busy_at_done", 32'(w ? busy16 : busy8), 32'd0);
    rs = w ? sum16 : {8'h00, sum8};
    rc = w ? co16 : co8;
    rv = w ? ov16 : ov8;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (w ? done16 : done8) extra++;
    end
  endtask

  initial begin
    vec_t        tbl[11];
    logic [15:0] rs;
    logic        rc, rv;
    int          bc, extra, cyc;
    tests = 0; fails = 0;
    tbl[0]  = '{0, 16'h5A, 16'h33, 1'b0, 0, 16'h8D, 1'b0, 1'b1};
    tbl[1]  = '{0, 16'h10, 16'h20, 1'b1, 0, 16'hF0, 1'b0, 1'b0};
    tbl[2]  = '{0, 16'h80, 16'h01, 1'b1, 0, 16'h7F, 1'b1, 1'b1};
    tbl[3]  = '{0, 16'hFF, 16'h01, 1'b0, 1, 16'h00, 1'b1, 1'b0};
    tbl[4]  = '{0, 16'h7F, 16'h01, 1'b0, 0, 16'h80, 1'b0, 1'b1};
    tbl[5]  = '{0, 16'h00, 16'h00, 1'b1, 0, 16'h00, 1'b1, 1'b0};
    tbl[6]  = '{0, 16'h80, 16'h80, 1'b0, 0, 16'h00, 1'b1, 1'b1};
    tbl[7]  = '{0, 16'h33, 16'h5A, 1'b1, 0, 16'hD9, 1'b0, 1'b0};
    tbl[8]  = '{0, 16'hFF, 16'hFF, 1'b1, 0, 16'h00, 1'b1, 1'b0};
    tbl[9]  = '{1, 16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
    tbl[10] = '{1, 16'h1234, 16'h4321, 1'b1, 1, 16'hCF13, 1'b0, 1'b0};
    rst_n = 1'b0; start8 = 0; start16 = 0; sub8 = 0; sub16 = 0;
    a8 = 0; b8 = 0; a16 = 0; b16 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_done8", 32'(done8), 0);
    chk("rst_sum8", 32'(sum8), 0);
    chk("rst_flags8", 32'({co8, ov8}), 0);
    chk("rst_busy16", 32'(busy16), 0);
    chk("rst_sum16", 32'(sum16), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      op(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].dis, rs, rc, rv, bc, extra);
      chk($sformatf("v%0d_sum", i), 32'(rs), 32'(tbl[i].sum));
      chk($sformatf("v%0d_co", i), 32'(rc), 32'(tbl[i].co));
      chk($sformatf("v%0d_ov", i), 32'(rv), 32'(tbl[i].ov));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), tbl[i].w ? 32'd4 : 32'd8);
      chk($sformatf("v%0d_extra_done", i), 32'(extra), 32'd0);
      chk($sformatf("v%0d_sum_held", i), tbl[i].w ? 32'(sum16) : 32'(sum8), 32'(tbl[i].sum));
    end

    // Back-to-back: start held high in DONE launches the next op immediately.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; cyc = 0;
    while (!done8 && cyc < 40) begin cyc++; @(negedge clk); end
    chk("b2b_timeout1", 32'(cyc >= 40), 0);
    chk("b2b_first_sum", 32'(sum8), 32'h8D);
    a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
    @(negedge clk);
    chk("b2b_busy_again", 32'(busy8), 1);
    chk("b2b_first_held", 32'(sum8), 32'h8D);
    start8 = 1'b0; bc = 0; cyc = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) bc++;
      cyc++;
      @(negedge clk);
    end
    chk("b2b_timeout2", 32'(cyc >= 40), 0);
    chk("b2b_busy_cycles", 32'(bc), 8);
    chk("b2b_second_sum", 32'(sum8), 32'h03);

    // Asynchronous reset in RUN cycle 4.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h33; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before", 32'(busy8), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy8), 0);
    chk("mid_rst_done", 32'(done8), 0);
    chk("mid_rst_sum", 32'(sum8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    chk("mid_rst_no_done", 32'(extra), 0);
    op(0, 16'h10, 16'h20, 1'b1, 0, rs, rc, rv, bc, extra);
    chk("post_rst_sum", 32'(rs), 32'hF0);
    chk("post_rst_flags", 32'({rc, rv}), 0);

    // Random operations on the 16-bit/4-digit instance.
    for (int i = 0; i < 200; i++) begin
      logic [15:0] av, bv, es;
      logic        sv, ec, ev;
      int          r;
      av = 16'($urandom); bv = 16'($urandom); sv = 1'($urandom);
      es = sv ? av - bv : av + bv;
      ec = sv ? (av >= bv) : ((32'(av) + 32'(bv)) > 32'hFFFF);
      r  = sv ? int'($signed(av)) - int'($signed(bv)) : int'($signed(av)) + int'($signed(bv));
      ev = (r > 32767) || (r < -32768);
      op(1, av, bv, sv, 0, rs, rc, rv, bc, extra);
      chk($sformatf("rnd%0d_sum", i), 32'(rs), 32'(es));
      chk($sformatf("rnd%0d_co", i), 32'(rc), 32'(ec));
      chk($sformatf("rnd%0d_ov", i), 32'(rv), 32'(ev));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
